// File: rtl/synth_test_sequencer.sv
// Sequencer that resets generated DUTs, fires each test_req in turn and collects results.
// Define SYNTH_TEST_SEQ_REPORT_EN to print per-test and final results and $finish on DONE.
module synth_test_sequencer #(
  parameter int unsigned NUM_TESTS   = 4,
  parameter int unsigned RESET_HOLD  = 6,
  parameter int unsigned START_DELAY = 100,
  parameter int unsigned TIMEOUT     = 200000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 dut_reset,
  output logic [NUM_TESTS-1:0] test_req,
  input  logic [NUM_TESTS-1:0] test_busy,
  input  logic [NUM_TESTS-1:0] test_return,
  output logic [4:0]           cur_test,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] tmo_mask
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST,
    S_SETTLE,
    S_REQ,
    S_GUARD,
    S_WAIT,
    S_RECOVER,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] L_RH      = CNT_W'(RESET_HOLD);
  localparam logic [CNT_W-1:0] L_RH_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] L_SD_LAST = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] L_RC_LAST =
    CNT_W'(RESET_HOLD + START_DELAY - 1);
  localparam logic [CNT_W-1:0] L_TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
  localparam logic [4:0]       L_LAST    = 5'(NUM_TESTS - 1);
  localparam logic [NUM_TESTS-1:0] L_ONE = NUM_TESTS'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [4:0]           r_cur;
  logic [4:0]           w_cur_nxt;
  logic [NUM_TESTS-1:0] r_fail;
  logic [NUM_TESTS-1:0] w_fail_nxt;
  logic [NUM_TESTS-1:0] r_tmo;
  logic [NUM_TESTS-1:0] w_tmo_nxt;
  logic [NUM_TESTS-1:0] w_sel;
  logic                 w_busy;
  logic                 w_ret;

  assign w_sel     = L_ONE << r_cur;
  assign w_busy    = |(test_busy & w_sel);
  assign w_ret     = |(test_return & w_sel);
  // Saturating count: a hung DUT must never wrap back under TIMEOUT
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + L_CNT_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cur   <= '0;
      r_fail  <= '0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cur   <= w_cur_nxt;
      r_fail  <= w_fail_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_inc;
    w_cur_nxt   = r_cur;
    w_fail_nxt  = r_fail;
    w_tmo_nxt   = r_tmo;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_cnt_nxt = '0;
        if (start) begin
          w_state_nxt = S_RST;
          w_cur_nxt   = '0;
          w_fail_nxt  = '0;
          w_tmo_nxt   = '0;
        end
      end
      S_RST: begin
        if (r_cnt == L_RH_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (START_DELAY == 0) ? S_REQ : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == L_SD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (r_cnt == L_CNT_ONE) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins when busy drops on the TIMEOUT cycle itself
        if (!w_busy) begin
          w_fail_nxt  = (r_fail & ~w_sel) | (w_sel & {NUM_TESTS{~w_ret}});
          w_state_nxt = S_NEXT;
        end else if (r_cnt >= L_TMO) begin
          w_fail_nxt  = r_fail | w_sel;
          w_tmo_nxt   = r_tmo | w_sel;
          w_cnt_nxt   = '0;
          w_state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (r_cnt == L_RC_LAST) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_cnt_nxt = '0;
        if (r_cur == L_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cur_nxt   = r_cur + 5'd1;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dut_reset = ~reset
                   | (r_state == S_RST)
                   | ((r_state == S_RECOVER) && (r_cnt < L_RH));
  assign test_req  = (r_state == S_REQ) ? w_sel : '0;
  assign cur_test  = r_cur;
  assign running   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign pass      = done && ~|{r_fail, r_tmo};
  assign fail_mask = r_fail;
  assign tmo_mask  = r_tmo;

`ifdef SYNTH_TEST_SEQ_REPORT_EN
  always_ff @(posedge clk) begin
    if (reset && r_state == S_WAIT && w_state_nxt != S_WAIT) begin
      if (w_state_nxt == S_RECOVER)
        $display("test %0d: TIMEOUT", r_cur);
      else if (w_ret)
        $display("test %0d: SUCCESS", r_cur);
      else
        $display("test %0d: *** FAILURE ***", r_cur);
    end
    if (reset && r_state == S_NEXT && w_state_nxt == S_DONE) begin
      if (~|{w_fail_nxt, w_tmo_nxt})
        $display("%m: TEST SUCCESS");
      else
        $display("%m: TEST *** FAILURE ***");
      $finish;
    end
  end
`endif

endmodule

// File: tb/tb_synth_test_sequencer.sv
// Scoreboard bench: expected request schedule and results are queued
// at start, then compared against what the sequencer actually does.
module tb_synth_test_sequencer;

  localparam int NT  = 4;
  localparam int RH  = 6;
  localparam int SD  = 100;
  localparam int TMO = 1000;

  typedef struct {
    int ch;
    int cyc;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          dut_reset;
  logic [NT-1:0] test_req;
  logic [NT-1:0] test_busy;
  logic [NT-1:0] test_return;
  logic [4:0]    cur_test;
  logic          running;
  logic          done;
  logic          pass;
  logic [NT-1:0] fail_mask;
  logic [NT-1:0] tmo_mask;

  int n_tests = 0;
  int n_fail  = 0;
  int tb_cyc  = 0;

  int            cfg_len [NT];
  logic [NT-1:0] cfg_stuck;
  int            bcnt [NT];
  logic [NT-1:0] stk;

  req_t exp_q[$];
  req_t obs_q[$];

  synth_test_sequencer #(
    .NUM_TESTS(NT), .RESET_HOLD(RH), .START_DELAY(SD),
    .TIMEOUT(TMO), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start),
    .dut_reset(dut_reset), .test_req(test_req),
    .test_busy(test_busy), .test_return(test_return),
    .cur_test(cur_test), .running(running), .done(done),
    .pass(pass), .fail_mask(fail_mask), .tmo_mask(tmo_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // Behavioural DUTs: busy rises the cycle after req, lasts cfg_len cycles
  always @(posedge clk) begin
    for (int i = 0; i < NT; i++) begin
      if (dut_reset) begin
        bcnt[i] <= 0;
        stk[i]  <= 1'b0;
      end else if (test_req[i]) begin
        if (cfg_stuck[i]) stk[i] <= 1'b1;
        else bcnt[i] <= cfg_len[i];
      end else if (bcnt[i] > 0) begin
        bcnt[i] <= bcnt[i] - 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NT; i++)
      test_busy[i] = stk[i] | (bcnt[i] != 0);
  end

  function automatic int oh_idx(input logic [NT-1:0] v);
    int r;
    r = -1;
    if ($onehot(v))
      for (int i = 0; i < NT; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic set_cfg(input int l0, input int l1, input int l2,
                         input int l3, input logic [NT-1:0] ret,
                         input logic [NT-1:0] stuck);
    cfg_len[0] = l0;
    cfg_len[1] = l1;
    cfg_len[2] = l2;
    cfg_len[3] = l3;
    test_return = ret;
    cfg_stuck = stuck;
  endtask

  task automatic run_seq(input string nm, input int hold,
                         input logic [NT-1:0] e_fail,
                         input logic [NT-1:0] e_tmo);
    int s, t, n_to, nrst, done_cyc, e_rst, k;
    bit got, bad;
    req_t e, o;
    exp_q.delete();
    obs_q.delete();
    @(negedge clk);
    start = 1'b1;
    s = tb_cyc + 1;
    t = s + RH + SD;
    n_to = 0;
    for (int i = 0; i < NT; i++) begin
      exp_q.push_back('{ch: i, cyc: t});
      if (cfg_stuck[i] || cfg_len[i] > TMO) begin
        t += TMO + RH + SD + 3;
        n_to++;
      end else begin
        t += cfg_len[i] + 3;
      end
    end
    e_rst = RH * (1 + n_to);
    nrst = 0;
    got = 0;
    done_cyc = 0;
    for (k = 0; k < 8000; k++) begin
      @(negedge clk);
      if (k + 1 >= hold) start = 1'b0;
      if (k == 0) begin
        n_tests++;
        if ({fail_mask, tmo_mask, done} !== '0) begin
          n_fail++;
          $display("FAIL %s clear_on_rst: masks=%b/%b done=%b want 0",
                   nm, fail_mask, tmo_mask, done);
        end
      end
      if (test_req != '0)
        obs_q.push_back('{ch: oh_idx(test_req), cyc: tb_cyc});
      if (dut_reset) nrst++;
      if (done) begin
        done_cyc = tb_cyc;
        got = 1;
        break;
      end
    end
    start = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s done_wait: done never rose, want done", nm);
      return;
    end
    n_tests++;
    if (done_cyc !== t) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d want %0d",
               nm, done_cyc - s, t - s);
    end
    n_tests++;
    if (fail_mask !== e_fail) begin
      n_fail++;
      $display("FAIL %s fail_mask: got %b want %b", nm, fail_mask, e_fail);
    end
    n_tests++;
    if (tmo_mask !== e_tmo) begin
      n_fail++;
      $display("FAIL %s tmo_mask: got %b want %b", nm, tmo_mask, e_tmo);
    end
    n_tests++;
    if (pass !== (e_fail == '0 && e_tmo == '0)) begin
      n_fail++;
      $display("FAIL %s pass: got %b want %b",
               nm, pass, (e_fail == '0 && e_tmo == '0));
    end
    n_tests++;
    if (nrst !== e_rst) begin
      n_fail++;
      $display("FAIL %s dut_reset_cycles: got %0d want %0d", nm, nrst, e_rst);
    end
    n_tests++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL %s running_in_done: got %b want 0", nm, running);
    end
    n_tests++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s req_count: got %0d want %0d",
               nm, obs_q.size(), exp_q.size());
    end
    bad = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o.ch !== e.ch || o.cyc !== e.cyc) begin
        n_fail++;
        $display("FAIL %s req: got ch%0d@%0d want ch%0d@%0d",
                 nm, o.ch, o.cyc - s, e.ch, e.cyc - s);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    set_cfg(5, 5, 5, 5, 4'b1111, 4'b0000);
    repeat (3) @(negedge clk);
    n_tests++;
    if (dut_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset dut_reset: got %b want 1", dut_reset);
    end
    n_tests++;
    if ({test_req, cur_test, running, done, pass, fail_mask, tmo_mask}
        !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: req=%b cur=%0d run=%b done=%b pass=%b",
               test_req, cur_test, running, done, pass);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if ({dut_reset, running, done, test_req} !== '0) begin
      n_fail++;
      $display("FAIL idle_hold: dut_reset=%b run=%b done=%b want 0",
               dut_reset, running, done);
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    int bad;
    set_cfg(20, 300, 300, 300, 4'b1110, 4'b0000);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (test_req[1]) begin
        seen = 1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midrst_req1: no req on ch1, want req");
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (fail_mask !== 4'b0001 || cur_test !== 5'd1) begin
      n_fail++;
      $display("FAIL midrst_pre: fail=%b cur=%0d want 0001/1",
               fail_mask, cur_test);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut_reset !== 1'b1 ||
        {test_req, cur_test, running, done, pass, fail_mask, tmo_mask}
        !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: dut_rst=%b cur=%0d run=%b fail=%b",
               dut_reset, cur_test, running, fail_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ({dut_reset, running, done, test_req} !== '0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midrst_idle: %0d busy cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    set_cfg(50, 50, 50, 50, 4'b1111, 4'b0000);
    run_seq("basic", 1, 4'b0000, 4'b0000);
    set_cfg(10, 20, 5, 30, 4'b1101, 4'b0000);
    run_seq("returns", 1, 4'b0010, 4'b0000);
    set_cfg(100, 100, 100, 100, 4'b1111, 4'b0000);
    run_seq("start_held", 300, 4'b0000, 4'b0000);
    set_cfg(8, 8, 8, 8, 4'b1111, 4'b0100);
    run_seq("stuck", 1, 4'b0100, 4'b0100);
    set_cfg(5, TMO, 5, 5, 4'b1111, 4'b0000);
    run_seq("edge_tmo", 1, 4'b0000, 4'b0000);
    set_cfg(TMO + 1, 5, 5, 7, 4'b1011, 4'b0000);
    run_seq("over_tmo", 1, 4'b0101, 4'b0001);
    test_mid_reset();
    set_cfg(12, 7, 9, 3, 4'b1111, 4'b0000);
    run_seq("after_rst", 1, 4'b0000, 4'b0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
